// File: rtl/commit_pkg.sv
// commit_pkg: shared defaults, index types and helpers for the N-wide
// retirement unit (commit_wide) and its lane selector (commit_select).
package commit_pkg;

  localparam int unsigned AL_DEPTH_DEF     = 64;
  localparam int unsigned COMMIT_WIDTH_DEF = 4;
  localparam int unsigned WB_PORTS_DEF     = 2;
  localparam int unsigned PREG_IDX_DEF     = 6;

  localparam int unsigned AL_IDX_W_DEF = $clog2(AL_DEPTH_DEF);

  typedef logic [AL_IDX_W_DEF-1:0] al_idx_t;
  typedef logic [PREG_IDX_DEF-1:0] preg_idx_t;
  typedef logic [AL_IDX_W_DEF:0]   al_cnt_t;

  typedef struct packed {
    logic      uses_rw;
    logic      is_load;
    logic      is_store;
    logic      is_branch;
    preg_idx_t reclaim_reg;
  } commit_lane_t;

  // Population count over up to eight lanes (COMMIT_WIDTH is 1..8).
  function automatic int unsigned popcnt8(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 8; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/commit_select.sv
// commit_select: combinational prefix-AND lane selection for the retirement
// window. Lane k commits only if all lower lanes commit, it is live, ready,
// passes the one-store-per-cycle limit and lies at or before the flush point.
// Ports: ready_win/is_* (window metadata), occupancy, store_grant,
// flush_valid/flush_dist -> commit_valid, commit_cnt, load_done_cnt,
// branch_done_cnt, store_done.
import commit_pkg::*;

module commit_select #(
  parameter int unsigned COMMIT_WIDTH = COMMIT_WIDTH_DEF,
  parameter int unsigned AL_IDX_W     = AL_IDX_W_DEF,
  parameter int unsigned CNT_W        = $clog2(COMMIT_WIDTH_DEF) + 1
) (
  input  logic [COMMIT_WIDTH-1:0] ready_win,
  input  logic [COMMIT_WIDTH-1:0] is_load,
  input  logic [COMMIT_WIDTH-1:0] is_store,
  input  logic [COMMIT_WIDTH-1:0] is_branch,
  input  logic [AL_IDX_W:0]       occupancy,
  input  logic                    store_grant,
  input  logic                    flush_valid,
  input  logic [AL_IDX_W-1:0]     flush_dist,
  output logic [COMMIT_WIDTH-1:0] commit_valid,
  output logic [CNT_W-1:0]        commit_cnt,
  output logic [CNT_W-1:0]        load_done_cnt,
  output logic [CNT_W-1:0]        branch_done_cnt,
  output logic                    store_done
);

  localparam int unsigned OW = AL_IDX_W + 1;

  logic w_chain;
  logic w_ok;
  logic w_store_seen;

  always_comb begin
    commit_valid = '0;
    w_chain      = 1'b1;
    w_ok         = 1'b0;
    w_store_seen = 1'b0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      w_ok = w_chain && ready_win[k] && (OW'(k) < occupancy);
      if (is_store[k]) w_ok = w_ok && store_grant && !w_store_seen;
      if (flush_valid) w_ok = w_ok && (AL_IDX_W'(k) <= flush_dist);
      commit_valid[k] = w_ok;
      w_chain         = w_ok;
      if (w_ok && is_store[k]) w_store_seen = 1'b1;
    end
    store_done = w_store_seen;
  end

  assign commit_cnt      = CNT_W'(popcnt8(8'(commit_valid)));
  assign load_done_cnt   = CNT_W'(popcnt8(8'(commit_valid & is_load)));
  assign branch_done_cnt = CNT_W'(popcnt8(8'(commit_valid & is_branch)));

endmodule

// File: rtl/commit_wide.sv
// commit_wide: N-wide in-order retirement unit. Tracks writeback completion
// per active-list entry and retires up to COMMIT_WIDTH oldest ready entries
// per cycle, with register reclaim, load/store/branch retirement counts and
// flush-driven tail recovery.
// Ports: clk, rst (sync, active-high); wb_valid/wb_id writebacks; alloc_cnt
// tail allocation; flush_valid/flush_id recovery; store_grant; head_* window
// metadata -> head_ptr, commit_valid, reclaim_valid/reclaim_reg, commit_cnt,
// load_done_cnt, branch_done_cnt, store_done, occupancy, full, empty.
// Optional macro COMMIT_TRACE_EN adds head_pc, trace_valid, trace_pc and the
// retired_total counter.
import commit_pkg::*;

module commit_wide #(
  parameter int unsigned AL_DEPTH     = AL_DEPTH_DEF,
  parameter int unsigned COMMIT_WIDTH = COMMIT_WIDTH_DEF,
  parameter int unsigned WB_PORTS     = WB_PORTS_DEF,
  parameter int unsigned PREG_IDX     = PREG_IDX_DEF,
  localparam int unsigned AL_IDX_W    = $clog2(AL_DEPTH),
  localparam int unsigned CNT_W       = $clog2(COMMIT_WIDTH) + 1,
  localparam int unsigned OW          = AL_IDX_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WB_PORTS-1:0]              wb_valid,
  input  logic [WB_PORTS*AL_IDX_W-1:0]     wb_id,
  input  logic [CNT_W-1:0]                 alloc_cnt,
  input  logic                             flush_valid,
  input  logic [AL_IDX_W-1:0]              flush_id,
  input  logic                             store_grant,
  input  logic [COMMIT_WIDTH-1:0]          head_uses_rw,
  input  logic [COMMIT_WIDTH-1:0]          head_is_load,
  input  logic [COMMIT_WIDTH-1:0]          head_is_store,
  input  logic [COMMIT_WIDTH-1:0]          head_is_branch,
  input  logic [COMMIT_WIDTH*PREG_IDX-1:0] head_reclaim_reg,
`ifdef COMMIT_TRACE_EN
  input  logic [COMMIT_WIDTH*32-1:0]       head_pc,
  output logic [COMMIT_WIDTH-1:0]          trace_valid,
  output logic [COMMIT_WIDTH*32-1:0]       trace_pc,
  output logic [31:0]                      retired_total,
`endif
  output logic [AL_IDX_W-1:0]              head_ptr,
  output logic [COMMIT_WIDTH-1:0]          commit_valid,
  output logic [COMMIT_WIDTH-1:0]          reclaim_valid,
  output logic [COMMIT_WIDTH*PREG_IDX-1:0] reclaim_reg,
  output logic [CNT_W-1:0]                 commit_cnt,
  output logic [CNT_W-1:0]                 load_done_cnt,
  output logic [CNT_W-1:0]                 branch_done_cnt,
  output logic                             store_done,
  output logic [OW-1:0]                    occupancy,
  output logic                             full,
  output logic                             empty
);

  localparam int unsigned MAX_ALLOC = (1 << CNT_W) - 1;

  logic [AL_DEPTH-1:0]     r_ready, w_ready_next;
  logic [AL_IDX_W-1:0]     r_head, r_tail, w_head_next, w_tail_next;
  logic [OW-1:0]           r_occ, w_occ_next, w_free;
  logic [COMMIT_WIDTH-1:0] w_ready_win, w_commit_valid;
  logic [AL_IDX_W-1:0]     w_flush_dist;
  logic [CNT_W-1:0]        w_commit_cnt;
  logic                    w_alloc_ok;

  always_comb begin
    w_ready_win = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++)
      w_ready_win[k] = r_ready[r_head + AL_IDX_W'(k)];
  end

  assign w_flush_dist = flush_id - r_head;
  assign w_free       = OW'(AL_DEPTH) - r_occ;
  assign w_alloc_ok   = (32'(alloc_cnt) <= 32'(w_free));

  commit_select #(
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .AL_IDX_W     (AL_IDX_W),
    .CNT_W        (CNT_W)
  ) u_select (
    .ready_win       (w_ready_win),
    .is_load         (head_is_load),
    .is_store        (head_is_store),
    .is_branch       (head_is_branch),
    .occupancy       (r_occ),
    .store_grant     (store_grant),
    .flush_valid     (flush_valid),
    .flush_dist      (w_flush_dist),
    .commit_valid    (w_commit_valid),
    .commit_cnt      (w_commit_cnt),
    .load_done_cnt   (load_done_cnt),
    .branch_done_cnt (branch_done_cnt),
    .store_done      (store_done)
  );

  always_comb begin
    w_head_next = r_head + AL_IDX_W'(w_commit_cnt);
    w_tail_next = r_tail;
    w_occ_next  = r_occ - OW'(w_commit_cnt);
    if (flush_valid) begin
      w_tail_next = flush_id + AL_IDX_W'(1);
      w_occ_next  = {1'b0, AL_IDX_W'(flush_id + AL_IDX_W'(1) - w_head_next)};
    end else if (w_alloc_ok) begin
      w_tail_next = r_tail + AL_IDX_W'(alloc_cnt);
      w_occ_next  = w_occ_next + OW'(alloc_cnt);
    end
  end

  // Update order sets precedence: writeback, then retire/alloc/flush clears.
  always_comb begin
    w_ready_next = r_ready;
    for (int unsigned p = 0; p < WB_PORTS; p++)
      if (wb_valid[p] &&
          ({1'b0, AL_IDX_W'(wb_id[p*AL_IDX_W +: AL_IDX_W] - r_head)} < r_occ))
        w_ready_next[wb_id[p*AL_IDX_W +: AL_IDX_W]] = 1'b1;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++)
      if (w_commit_valid[k]) w_ready_next[r_head + AL_IDX_W'(k)] = 1'b0;
    if (!flush_valid && w_alloc_ok)
      for (int unsigned i = 0; i < MAX_ALLOC; i++)
        if (i < 32'(alloc_cnt)) w_ready_next[r_tail + AL_IDX_W'(i)] = 1'b0;
    // Everything outside the surviving range is cleared, squashed or free.
    if (flush_valid)
      for (int unsigned i = 0; i < AL_DEPTH; i++)
        if ({1'b0, AL_IDX_W'(AL_IDX_W'(i) - w_head_next)} >= w_occ_next)
          w_ready_next[AL_IDX_W'(i)] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_occ   <= '0;
    end else begin
      r_ready <= w_ready_next;
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_occ   <= w_occ_next;
      if (!flush_valid) begin
        assert (w_alloc_ok)
          else $warning("commit_wide: alloc_cnt %0d exceeds free space %0d",
                        alloc_cnt, w_free);
        for (int unsigned p = 0; p < WB_PORTS; p++)
          assert (!(wb_valid[p] && w_alloc_ok &&
                    (32'(AL_IDX_W'(wb_id[p*AL_IDX_W +: AL_IDX_W] - r_tail)) <
                     32'(alloc_cnt))))
            else $warning("commit_wide: writeback to id being allocated");
      end
    end
  end

  assign head_ptr      = r_head;
  assign occupancy     = r_occ;
  assign full          = (r_occ == OW'(AL_DEPTH));
  assign empty         = (r_occ == '0);
  assign commit_valid  = w_commit_valid;
  assign commit_cnt    = w_commit_cnt;
  assign reclaim_valid = w_commit_valid & head_uses_rw;

  always_comb begin
    reclaim_reg = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++)
      if (reclaim_valid[k])
        reclaim_reg[k*PREG_IDX +: PREG_IDX] = head_reclaim_reg[k*PREG_IDX +: PREG_IDX];
  end

`ifdef COMMIT_TRACE_EN
  logic [31:0] r_retired_total;

  always_ff @(posedge clk) begin
    if (rst) r_retired_total <= '0;
    else     r_retired_total <= r_retired_total + 32'(w_commit_cnt);
  end

  assign retired_total = r_retired_total;
  assign trace_valid   = w_commit_valid;

  always_comb begin
    trace_pc = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++)
      if (w_commit_valid[k]) trace_pc[k*32 +: 32] = head_pc[k*32 +: 32];
  end
`endif

endmodule
